// File: rtl/hpfp_mult_pkg.sv
// Shared HPFP multiply-path definitions: sequencer state encoding and
// half-precision mantissa/product widths.
package hpfp_mult_pkg;

    localparam int MANT_W = 11;
    localparam int PROD_W = 22;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REDUCE  = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } mult_state_e;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_REDUCE  = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/csa_mult_sequencer_csa.sv
// 3:2 carry-save adder. The carry vector comes out one bit wider and
// already shifted left by one (bit 0 is always zero).
module csa_mult_sequencer_csa #(
    parameter int W = 22
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [W-1:0] c,
    output logic [W-1:0] s,
    output logic [W:0]   cout
);

    assign s    = a ^ b ^ c;
    assign cout = {(a & b) | (a & c) | (b & c), 1'b0};

endmodule

// File: rtl/csa_mult_sequencer.sv
// Iterative unsigned mantissa multiplier: one partial product per cycle through
// a shared 3:2 CSA, then one carry-propagate add. Option: CSA_EARLY_TERM_EN.
module csa_mult_sequencer
    import hpfp_mult_pkg::*;
#(
    parameter int WIDTH = MANT_W,
    parameter int ACC_W = 2 * WIDTH,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] product,
    output logic             busy,
    output logic [1:0]       state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // in_ready is high only in IDLE; out_valid holds the product until out_ready.

    logic [1:0]       state;
    logic [ACC_W-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [ACC_W-1:0] sum_q;
    logic [ACC_W-1:0] carry_q;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] b_shift;
    logic [ACC_W-1:0] pp;
    logic [ACC_W-1:0] csa_s;
    logic [ACC_W:0]   csa_c;
    logic             last_bit;
    logic             unused_carry_msb;

    assign b_shift = b_q >> cnt;
    assign pp      = b_shift[0] ? (a_q << cnt) : '0;

`ifdef CSA_EARLY_TERM_EN
    // Stop once no set multiplier bits remain above the current one.
    assign last_bit = (b_shift[WIDTH-1:1] == '0);
`else
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
`endif

    csa_mult_sequencer_csa #(.W(ACC_W)) u_csa (
        .a    (sum_q),
        .b    (carry_q),
        .c    (pp),
        .s    (csa_s),
        .cout (csa_c)
    );

    // The full product fits in ACC_W bits, so the carry MSB is always zero.
    assign unused_carry_msb = csa_c[ACC_W];

    assign in_ready  = (state == ST_IDLE);
    assign busy      = (state == ST_REDUCE) || (state == ST_RESOLVE);
    assign state_dbg = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sum_q     <= '0;
            carry_q   <= '0;
            cnt       <= '0;
            product   <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q     <= ACC_W'(op_a);
                        b_q     <= op_b;
                        sum_q   <= '0;
                        carry_q <= '0;
                        cnt     <= '0;
`ifdef CSA_EARLY_TERM_EN
                        state   <= (op_b == '0) ? ST_RESOLVE : ST_REDUCE;
`else
                        state   <= ST_REDUCE;
`endif
                    end
                end
                ST_REDUCE: begin
                    sum_q   <= csa_s;
                    carry_q <= csa_c[ACC_W-1:0];
                    cnt     <= cnt + 1'b1;
                    if (last_bit) begin
                        state <= ST_RESOLVE;
                    end
                end
                ST_RESOLVE: begin
                    product   <= sum_q + carry_q;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_mult_sequencer.sv
// Scoreboard bench for csa_mult_sequencer; latency model follows CSA_EARLY_TERM_EN.
module tb_csa_mult_sequencer;

    localparam int WIDTH = 11;
    localparam int ACC_W = 22;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] op_a = '0;
    logic [WIDTH-1:0] op_b = '0;
    logic             in_ready;
    logic             out_valid;
    logic [ACC_W-1:0] product;
    logic             busy;
    logic [1:0]       state_dbg;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [ACC_W-1:0] exp_q[$];
    int               due_q[$];

    logic             prev_valid = 1'b0;
    logic [ACC_W-1:0] held = '0;
    int               due = 0;

    csa_mult_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // clock/reset block
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model: plain arithmetic product and spec latency.
    function automatic logic [ACC_W-1:0] ref_product(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b);
        logic [ACC_W-1:0] wa;
        logic [ACC_W-1:0] wb;
        wa = ACC_W'(a);
        wb = ACC_W'(b);
        return wa * wb;
    endfunction

    function automatic int ref_latency(input logic [WIDTH-1:0] b);
        int hb;
        hb = -1;
        for (int k = 0; k < WIDTH; k++) if (b[k]) hb = k;
`ifdef CSA_EARLY_TERM_EN
        return (hb < 0) ? 1 : hb + 2;
`else
        return (hb < -1) ? 0 : WIDTH + 1;
`endif
    endfunction

    // monitor / scoreboard
    always begin
        @(posedge clk);
        cyc++;
        #1;
        if (!rst_n) begin
            prev_valid = 1'b0;
        end else begin
            if (prev_valid && out_ready) begin
                check("handshake out_valid", out_valid, 1'b0);
                check("handshake in_ready", in_ready, 1'b1);
            end else if (prev_valid) begin
                check("hold out_valid", out_valid, 1'b1);
                if (out_valid) check("hold product", product, held);
            end else if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got 0x%0h expected none (cycle %0d)", product, cyc);
                end else begin
                    held = exp_q.pop_front();
                    due  = due_q.pop_front();
                    check("product", product, held);
                    check("latency", 64'(cyc), 64'(due));
                end
            end
            if (out_valid) begin
                check("in_ready while valid", in_ready, 1'b0);
                check("busy while valid", busy, 1'b0);
            end else begin
                check("busy", busy, !in_ready);
            end
            prev_valid = out_valid;
        end
    end

    // driver
    task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int hold);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 (cycle %0d)", cyc);
            return;
        end
        in_valid = 1'b1;
        op_a     = a;
        op_b     = b;
        exp_q.push_back(ref_product(a, b));
        due_q.push_back(cyc + 1 + ref_latency(b));
        @(negedge clk);
        n = 0;
        while (!out_valid && n < 40) begin
            in_valid  = 1'($urandom_range(0, 1));
            op_a      = WIDTH'($urandom);
            op_b      = WIDTH'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        if (!out_valid) begin
            checks++;
            errors++;
            $display("FAIL out_valid_timeout: got 0 expected 1 (cycle %0d)", cyc);
            return;
        end
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        int n;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset in_ready", in_ready, 1'b1);
        check("reset out_valid", out_valid, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset product", product, '0);
        rst_n = 1'b1;

        do_op(11'h400, 11'h400, 0);
        do_op(11'h7FF, 11'h7FF, 0);
        do_op(11'h123, 11'h045, 5);
        do_op(11'h000, 11'h5A5, 0);
        do_op(11'h03A, 11'h000, 1);
        do_op(11'h7FF, 11'h001, 0);
        do_op(11'h001, 11'h7FF, 2);

        // Abort mid-reduction: nothing may be presented afterwards.
        @(negedge clk);
        n = 0;
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        in_valid = 1'b1;
        op_a     = 11'h7FF;
        op_b     = 11'h7FF;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("abort busy before reset", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("abort in_ready", in_ready, 1'b1);
        check("abort out_valid", out_valid, 1'b0);
        check("abort busy", busy, 1'b0);
        check("abort product", product, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(11'h003, 11'h005, 0);

        for (int t = 0; t < 40; t++) begin
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            if ((t % 8) == 3) rb = WIDTH'(1) << $urandom_range(0, WIDTH - 1);
            if ((t % 10) == 7) ra = '0;
            do_op(ra, rb, $urandom_range(0, 3));
        end

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        // final report
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
